pe_noc_endpoint: RTL

PE_NOC_ENDPOINT -- requirements
Module: pe_noc_endpoint

---
 rtl/pe_noc_endpoint_pkg.sv | 37 +++
 rtl/pe_tx_fifo.sv | 49 ++++
 rtl/pe_noc_endpoint.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pe_noc_endpoint_pkg.sv
// Shared flit layout, type codes and tx-queue entry format for the PE NoC endpoint.
package pe_noc_endpoint_pkg;

  localparam int FLIT_W     = 64;
  localparam int WEIGHTS_W  = 40;
  localparam int IFM_W      = 25;
  localparam int PAYLOAD_W  = 10;
  localparam logic [PAYLOAD_W-1:0] DONE_PAYLOAD = 10'h1FF;

  typedef enum logic [1:0] {
    FT_IFMAP  = 2'b00,
    FT_KERNEL = 2'b01,
    FT_RSVD   = 2'b10,
    FT_OUTPUT = 2'b11
  } flit_type_e;

  // Field order fixes the bit positions: src [63:60], dst [59:56], type [55:54].
  typedef struct packed {
    logic [3:0]  src;
    logic [3:0]  dst;
    flit_type_e  ftype;
    logic [53:0] body;
  } flit_t;

  typedef struct packed {
    logic       is_done;
    logic [4:0] row;
    logic [4:0] col;
  } tx_entry_t;

  localparam int TX_ENTRY_W = $bits(tx_entry_t);

  function automatic logic [PAYLOAD_W-1:0] tx_payload(input tx_entry_t e);
    return e.is_done ? DONE_PAYLOAD : {e.row, e.col};
  endfunction

endpackage

// File: rtl/pe_tx_fifo.sv
// Outbound spike/done queue: first-word-fall-through FIFO with full/empty flags.
module pe_tx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pe_noc_endpoint.sv
// PE NoC endpoint: rx demux of kernel/ifmap flits, tx queue of spike/done events.
// Optional PE_EP_DROP_CNT_EN adds a saturating 16-bit count of discarded flits.
module pe_noc_endpoint
  import pe_noc_endpoint_pkg::*;
#(
  parameter logic [3:0] MY_ADDR   = 4'b0000,
  parameter logic [3:0] MEM_ADDR  = 4'b0000,
  parameter int         TXQ_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [FLIT_W-1:0]    in_flit,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [FLIT_W-1:0]    out_flit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WEIGHTS_W-1:0] weights,
  output logic                 weights_loaded,
  output logic [IFM_W-1:0]     ifm_row,
  output logic                 ifm_valid,
  input  logic                 ifm_ready,
  input  logic [4:0]           spk_row,
  input  logic [4:0]           spk_col,
  input  logic                 spk_valid,
  output logic                 spk_ready,
  input  logic                 done_valid,
  output logic                 done_ready
`ifdef PE_EP_DROP_CNT_EN
  ,output logic [15:0]         drop_cnt
`endif
);

  flit_t                 in_f, out_f;
  logic                  for_me, ifm_hit, accept, drop;
  logic [WEIGHTS_W-1:0]  weights_q, weights_d;
  logic                  weights_loaded_q, weights_loaded_d;
  logic [IFM_W-1:0]      ifm_row_q, ifm_row_d;
  logic                  ifm_valid_q, ifm_valid_d;
  logic                  unused_in_bits;

  assign in_f           = in_flit;
  assign unused_in_bits = ^{in_f.src, in_f.body[53:WEIGHTS_W]};

  // ---------------- rx path ----------------
  // NOTE: every always_comb output gets a default first so no latch is inferred;
  // combinational blocks use blocking '=', clocked blocks use non-blocking '<='.
  always_comb begin
    for_me   = (in_f.dst == MY_ADDR);
    ifm_hit  = for_me && (in_f.ftype == FT_IFMAP);
    in_ready = !(ifm_hit && ifm_valid_q);
    accept   = in_valid && in_ready;
    drop     = accept && (!for_me || in_f.ftype[1]);

    weights_d        = weights_q;
    weights_loaded_d = weights_loaded_q;
    ifm_row_d        = ifm_row_q;
    ifm_valid_d      = ifm_valid_q;

    if (accept && for_me && (in_f.ftype == FT_KERNEL)) begin
      weights_d        = in_f.body[WEIGHTS_W-1:0];
      weights_loaded_d = 1'b1;
    end
    if (ifm_valid_q && ifm_ready) ifm_valid_d = 1'b0;
    // A new row can only be accepted once the previous one has been handed off.
    if (accept && ifm_hit) begin
      ifm_row_d   = in_f.body[IFM_W-1:0];
      ifm_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weights_q        <= '0;
      weights_loaded_q <= 1'b0;
      ifm_row_q        <= '0;
      ifm_valid_q      <= 1'b0;
    end else begin
      weights_q        <= weights_d;
      weights_loaded_q <= weights_loaded_d;
      ifm_row_q        <= ifm_row_d;
      ifm_valid_q      <= ifm_valid_d;
    end
  end

  assign weights        = weights_q;
  assign weights_loaded = weights_loaded_q;
  assign ifm_row        = ifm_row_q;
  assign ifm_valid      = ifm_valid_q;

`ifdef PE_EP_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

  // ---------------- tx path ----------------
  tx_entry_t tx_din, tx_head;
  logic      tx_push, tx_pop, tx_full, tx_empty;

  // Spikes win a same-cycle collision; the done marker simply waits a cycle.
  always_comb begin
    spk_ready  = !tx_full;
    done_ready = !tx_full && !spk_valid;
    tx_push    = (spk_valid && spk_ready) || (done_valid && done_ready);
    tx_din     = spk_valid ? tx_entry_t'{is_done: 1'b0, row: spk_row, col: spk_col}
                           : tx_entry_t'{is_done: 1'b1, row: 5'd0, col: 5'd0};
    tx_pop     = out_valid && out_ready;
  end

  pe_tx_fifo #(
    .WIDTH (TX_ENTRY_W),
    .DEPTH (TXQ_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .din   (tx_din),
    .pop   (tx_pop),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  always_comb begin
    out_f.src   = MY_ADDR;
    out_f.dst   = MEM_ADDR;
    out_f.ftype = FT_OUTPUT;
    out_f.body  = {44'b0, tx_payload(tx_head)};
  end

  assign out_valid = !tx_empty;
  assign out_flit  = out_f;

endmodule
